cam_stream_tx: RTL and testbench

CAM_STREAM_TX -- requirements
Module: cam_stream_tx

---
 rtl/cam_stream_tx.sv | 145 ++++++++++++++
 tb/tb_cam_stream_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_tx.sv
// Camera-format (vsync/href/8-bit) transmitter for a stream of RGB444 pixels.
// Each frame is a fixed number of lines; each pixel goes out as two bytes.
//
// state  | meaning
// IDLE   | waiting for i_en, outputs quiet
// VSYNC  | vsync lines, o_vsync high
// VFRONT | blank lines before the picture
// ACTIVE | picture lines, href high for 2*H_ACTIVE cycles per line
// VBACK  | blank lines after the picture, frame counted on its last cycle
module cam_stream_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_FRONT     = 17,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 10
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
  input  logic        i_pix_valid,
  input  logic [11:0] i_pix_data,
  output logic        o_pix_ready,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_underflow,
  output logic [7:0]  o_frame_cnt,
  output logic        o_busy
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int M1   = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int M2   = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
  localparam int MAXL = (M1 > M2) ? M1 : M2;
  localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VFRONT = 3'd2,
    ACTIVE = 3'd3,
    VBACK  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [LW-1:0]   line_q, line_d;
  logic [11:0]     pix_q;
  logic            underflow_q;
  logic [7:0]      frame_cnt_q;
  logic            line_end;
  logic            state_end;
  logic            frame_inc;
  logic            href;
  logic            ready;

  function automatic int lines_of(state_e s);
    case (s)
      VSYNC:   return VSYNC_LINES;
      VFRONT:  return V_FRONT;
      ACTIVE:  return V_ACTIVE;
      VBACK:   return V_BACK;
      default: return 1;
    endcase
  endfunction

  // First non-empty state of a frame; zero-line states are skipped.
  function automatic state_e first_st();
    if (VSYNC_LINES != 0) return VSYNC;
    if (V_FRONT != 0)     return VFRONT;
    if (V_ACTIVE != 0)    return ACTIVE;
    return VBACK;
  endfunction

  // Following non-empty state within the frame; IDLE marks the end of the frame.
  function automatic state_e after_st(state_e s);
    if (s == VSYNC && V_FRONT != 0) return VFRONT;
    if ((s == VSYNC || s == VFRONT) && V_ACTIVE != 0) return ACTIVE;
    if (s != VBACK && s != IDLE && V_BACK != 0) return VBACK;
    return IDLE;
  endfunction

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    line_d    = line_q;
    frame_inc = 1'b0;
    line_end  = (int'(h_q) == LINE - 1);
    state_end = line_end && (int'(line_q) == lines_of(state_q) - 1);
    if (state_q == IDLE) begin
      h_d    = '0;
      line_d = '0;
      if (i_en) state_d = first_st();
    end else begin
      h_d = line_end ? '0 : h_q + HW'(1);
      if (state_end) begin
        line_d = '0;
        if (after_st(state_q) == IDLE) begin
          frame_inc = 1'b1;
          state_d   = i_en ? first_st() : IDLE;
        end else begin
          state_d = after_st(state_q);
        end
      end else if (line_end) begin
        line_d = line_q + LW'(1);
      end
    end
  end

  // Ready looks one cycle ahead so the pixel is latched for the coming byte0.
  assign ready = (state_d == ACTIVE) && (int'(h_d) < 2 * H_ACTIVE) && !h_d[0];
  assign href  = (state_q == ACTIVE) && (int'(h_q) < 2 * H_ACTIVE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      h_q         <= '0;
      line_q      <= '0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      line_q  <= line_d;
      if (ready) begin
        pix_q <= i_pix_valid ? i_pix_data : 12'h000;
        if (!i_pix_valid) underflow_q <= 1'b1;
      end
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign o_pix_ready = ready;
  assign o_vsync     = (state_q == VSYNC);
  assign o_href      = href;
  assign o_data      = !href   ? 8'h00 :
                       h_q[0]  ? pix_q[7:0] : {4'h0, pix_q[11:8]};
  assign o_underflow = underflow_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx: a frame-position model (pixel queue, line/h
// arithmetic) predicts every output each cycle under directed and random input.
module tb_cam_stream_tx;
  localparam int HA = 4, HB = 2, VS = 1, VF = 1, VA = 2, VB = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VF + VA + VB);

  logic        clk = 1'b0;
  logic        rstn, en, valid;
  logic [11:0] data;
  logic        pix_ready, vsync, href, underflow, busy;
  logic [7:0]  odata, frame_cnt;

  always #5 clk = ~clk;

  cam_stream_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .VSYNC_LINES(VS),
                  .V_FRONT(VF), .V_ACTIVE(VA), .V_BACK(VB)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_pix_valid(valid),
    .i_pix_data(data), .o_pix_ready(pix_ready), .o_vsync(vsync),
    .o_href(href), .o_data(odata), .o_underflow(underflow),
    .o_frame_cnt(frame_cnt), .o_busy(busy));

  int errors = 0, checks = 0;

  // model: pos is the cycle index within the current frame, -1 when idle
  int          pos = -1;
  logic [11:0] q[$];
  logic [11:0] cur = 12'h000;
  bit          uf = 1'b0;
  int          fc = 0;
  int          frames_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h pos=%0d t=%0t", tag, got, exp, pos, $time);
    end
  endtask

  function automatic bit is_vs(int p);
    return p >= 0 && (p / LINE) < VS;
  endfunction

  function automatic bit is_href(int p);
    int l;
    if (p < 0) return 1'b0;
    l = p / LINE;
    return l >= VS + VF && l < VS + VF + VA && (p % LINE) < 2 * HA;
  endfunction

  function automatic bit is_byte0(int p);
    return is_href(p) && ((p % LINE) % 2 == 0);
  endfunction

  function automatic int next_pos(int p, bit e);
    if (p < 0 || p == FRAME - 1) return e ? 0 : -1;
    return p + 1;
  endfunction

  task automatic model_reset();
    pos = -1; q.delete(); uf = 1'b0; fc = 0; frames_done = 0;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_d;
    exp_d = 8'h00;
    if (is_href(pos)) begin
      if ((pos % LINE) % 2 == 0) exp_d = (q.size() > 0) ? {4'h0, q[0][11:8]} : 8'h00;
      else                       exp_d = cur[7:0];
    end
    chk("vsync", vsync, is_vs(pos));
    chk("href", href, is_href(pos));
    chk("data", odata, exp_d);
    chk("ready", pix_ready, rstn && is_byte0(next_pos(pos, en)));
    chk("underflow", underflow, uf);
    chk("frame_cnt", frame_cnt, fc[7:0]);
    chk("busy", busy, pos >= 0);
  endtask

  task automatic model_update();
    int np;
    if (!rstn) begin
      model_reset();
      return;
    end
    np = next_pos(pos, en);
    if (is_byte0(pos)) cur = (q.size() > 0) ? q.pop_front() : 12'h000;
    if (is_byte0(np)) begin
      q.push_back(valid ? data : 12'h000);
      if (!valid) uf = 1'b1;
    end
    if (pos == FRAME - 1) begin
      fc = (fc + 1) % 256;
      frames_done++;
    end
    pos = np;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_vs, n_href, n_rdy, fc_before;
    bit reached;
    rstn = 1'b0; en = 1'b0; valid = 1'b0; data = 12'h000;
    repeat (3) step();
    rstn = 1'b1;
    repeat (3) step();

    // three back-to-back frames of constant pixels
    en = 1'b1; valid = 1'b1; data = 12'hABC;
    n_vs = 0; n_href = 0; n_rdy = 0;
    for (int i = 0; i < 3 * FRAME + 1; i++) begin
      n_vs += int'(vsync); n_href += int'(href); n_rdy += int'(pix_ready);
      step();
    end
    chk("vsync_cycles", n_vs, 3 * VS * LINE);
    chk("href_cycles", n_href, 3 * VA * 2 * HA);
    chk("ready_pulses", n_rdy, 3 * VA * HA);
    chk("frames3", frame_cnt, 3);
    chk("no_gap_vsync", vsync, 1);

    // underflow on the second pixel of the first active line
    for (int i = 0; i < FRAME; i++) begin
      valid = (next_pos(pos, en) != (VS + VF) * LINE + 2);
      data  = 12'($urandom);
      step();
    end
    chk("uf_set", underflow, 1);

    // let the running frame finish, then a single-cycle enable pulse
    en = 1'b0; valid = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < FRAME + 5 && !reached; i++) begin
      step();
      reached = (pos < 0);
    end
    chk("reach_idle", reached, 1);
    repeat (4) step();
    fc_before = fc;
    en = 1'b1; step(); en = 1'b0;
    repeat (FRAME + 5) begin
      data = 12'($urandom);
      step();
    end
    chk("pulse_busy", busy, 0);
    chk("pulse_frames", frame_cnt, 8'(fc_before + 1));
    chk("uf_sticky", underflow, 1);

    // random enable / valid / data
    repeat (400) begin
      en    = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 7) != 0);
      data  = 12'($urandom);
      step();
    end

    // reset in the middle of the first active line
    en = 1'b1; valid = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      reached = (pos == (VS + VF) * LINE + 3);
      if (!reached) step();
    end
    chk("reach_h3", reached, 1);
    rstn = 1'b0; en = 1'b0;
    #1;
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_data", odata, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_fc", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk); #1;
    repeat (3) step();
    rstn = 1'b1;
    repeat (10) step();
    chk("idle_after_rst", busy, 0);
    en = 1'b1; step();
    chk("start_vsync", vsync, 1);

    // 256 frames from reset: the counter must wrap back to zero
    reached = 1'b0;
    for (int i = 0; i < 256 * FRAME + 200 && !reached; i++) begin
      en    = (frames_done < 255);
      valid = ($urandom_range(0, 15) != 0);
      data  = 12'($urandom);
      step();
      reached = (frames_done == 256 && pos < 0);
    end
    chk("wrap_done", reached, 1);
    chk("wrap_fc", frame_cnt, 0);
    chk("wrap_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
